// File: rtl/serdes_tx_sched_if.sv
// Link-layer word stream into the serializer scheduler: valid/ready handshake.
// Master drives data and valid; slave returns ready.
interface serdes_tx_sched_if #(
  parameter int WORD_W = 10
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/serdes_tx_sched.sv
// Feeds the PISO one word per WORD_W-clock slot: FIFO head in RUN, idle char when empty, training pattern in TRAIN.
// Load registered on the slot boundary; s_ready = !full, no bypass from input to PISO.
module serdes_tx_sched #(
  parameter int                WORD_W     = 10,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [WORD_W-1:0] IDLE_PAT   = 10'b0011111010,
  parameter logic [WORD_W-1:0] TRAIN_PAT  = 10'b1010101010
) (
  input  logic                            clk,
  input  logic                            rst,
  serdes_tx_sched_if.slave                s,
  input  logic                            tx_en,
  input  logic                            train_en,
  input  logic                            flush,
  output logic [WORD_W-1:0]               piso_par_in,
  output logic                            piso_load_en,
  output logic                            idle_ins,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [1:0]                      mode
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TRAIN = 2'd1,
    RUN   = 2'd2
  } mode_t;

  mode_t             state_q;
  mode_t             next_mode;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level;
  logic              boundary;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign s.s_ready  = !rst && !full;
  assign fifo_level = level;
  assign mode       = state_q;

  always_comb begin
    boundary  = (cnt == '0);
    next_mode = !tx_en ? OFF : (train_en ? TRAIN : RUN);
    full      = (level == LVL_W'(FIFO_DEPTH));
    empty     = (level == '0);
    push      = s.s_valid && s.s_ready && !flush;
    // A flush on a RUN boundary empties the queue first, so that slot carries idle.
    pop       = boundary && (next_mode == RUN) && !empty && !flush;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s.s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= OFF;
      cnt          <= '0;
      piso_load_en <= 1'b0;
      piso_par_in  <= '0;
      idle_ins     <= 1'b0;
    end else if (boundary) begin
      state_q  <= next_mode;
      idle_ins <= 1'b0;
      if (next_mode == OFF) begin
        piso_load_en <= 1'b0;
        cnt          <= '0;
      end else begin
        piso_load_en <= 1'b1;
        cnt          <= CNT_W'(1);
        if (next_mode == TRAIN) begin
          piso_par_in <= TRAIN_PAT;
        end else if (pop) begin
          piso_par_in <= mem[rd_ptr];
        end else begin
          piso_par_in <= IDLE_PAT;
          idle_ins    <= 1'b1;
        end
      end
    end else begin
      piso_load_en <= 1'b0;
      idle_ins     <= 1'b0;
      cnt          <= (cnt == CNT_W'(WORD_W - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Randomized bench for serdes_tx_sched against a queue-based slot model.
module tb_serdes_tx_sched;

  localparam int         W     = 10;
  localparam int         D     = 4;
  localparam logic [9:0] IDLE  = 10'b0011111010;
  localparam logic [9:0] TRAIN = 10'b1010101010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       train_en = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] par;
  logic       load;
  logic       idle;
  logic [2:0] lvl;
  logic [1:0] mode;

  serdes_tx_sched_if #(.WORD_W(W)) s_if();

  serdes_tx_sched #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (s_if),
    .tx_en        (tx_en),
    .train_en     (train_en),
    .flush        (flush),
    .piso_par_in  (par),
    .piso_load_en (load),
    .idle_ins     (idle),
    .fifo_level   (lvl),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: a word queue plus "clocks since last slot start"
  logic [9:0] m_q[$];
  int         m_pos;
  int         m_mode;
  logic [9:0] m_par;
  logic       m_load;
  logic       m_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pos  = 0;
    m_mode = 0;
    m_par  = '0;
    m_load = 1'b0;
    m_idle = 1'b0;
  endfunction

  function automatic void model_step();
    bit acc;
    int nm;
    acc = s_if.s_valid && (m_q.size() < D);
    if (m_pos == 0) begin
      nm     = !tx_en ? 0 : (train_en ? 1 : 2);
      m_mode = nm;
      m_idle = 1'b0;
      if (nm == 0) begin
        m_load = 1'b0;
      end else begin
        m_load = 1'b1;
        m_pos  = 1;
        if (nm == 1) begin
          m_par = TRAIN;
        end else if (m_q.size() != 0 && !flush) begin
          m_par = m_q.pop_front();
        end else begin
          m_par  = IDLE;
          m_idle = 1'b1;
        end
      end
    end else begin
      m_load = 1'b0;
      m_idle = 1'b0;
      m_pos  = (m_pos + 1) % W;
    end
    if (flush) m_q.delete();
    else if (acc) m_q.push_back(s_if.s_data);
  endfunction

  task automatic check_outputs();
    chk("load_en", load, m_load);
    chk("par_in", par, m_par);
    chk("idle_ins", idle, m_idle);
    chk("fifo_level", lvl, m_q.size());
    chk("mode", mode, m_mode);
    chk("s_ready", s_if.s_ready, (!rst && m_q.size() < D));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_outputs();
  endtask

  task automatic push(input logic [9:0] d);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    tick();
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    while (load !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("wait_load", load, 1);
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    model_reset();

    repeat (2) tick();
    rst = 1'b0;

    repeat (50) tick();

    tx_en = 1'b1;
    train_en = 1'b1;
    repeat (35) tick();

    train_en = 1'b0;
    push(10'h155);
    push(10'h2AA);
    repeat (40) tick();

    tx_en = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < 5; i++) push(10'(10'h101 + i * 10'h23));
    chk("full_level", lvl, 4);
    chk("full_ready", s_if.s_ready, 0);
    tx_en = 1'b1;
    repeat (50) tick();

    wait_load();
    repeat (2) tick();
    tx_en = 1'b0;
    repeat (20) tick();
    chk("off_mode", mode, 0);

    push(10'h0F0);
    push(10'h30F);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 10'h3C3;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    s_if.s_valid = 1'b0;
    chk("flush_level", lvl, 0);

    for (int i = 0; i < 4; i++) push(10'(10'h200 + i));
    tx_en = 1'b1;
    wait_load();
    repeat (4) tick();
    async_reset();
    chk("rst_level", lvl, 0);
    tick();
    chk("reidle_par", par, IDLE);
    chk("reidle_flag", idle, 1);

    for (int i = 0; i < 3000; i++) begin
      s_if.s_valid = ($urandom_range(0, 2) != 0);
      s_if.s_data  = 10'($urandom);
      flush        = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 49) == 0) train_en = ~train_en;
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
